// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full-adder cell and a carry flip-flop, LSB first.
// Accept on start in IDLE, N bit steps in ADD, one-cycle done pulse in DONE.
module serial_adder #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic [N-1:0]    r_ps;
  logic            r_c;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_done;
  logic [N-1:0]    r_sum;
  logic            r_cout;

  logic            w_s;
  logic            w_c;
  logic [N-1:0]    w_ps_next;

  // The single full-adder cell shared by every bit position.
  always_comb begin
    w_s       = r_a[0] ^ r_b[0] ^ r_c;
    w_c       = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
    w_ps_next = {w_s, r_ps[N-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_ps    <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_c     <= cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_c   <= w_c;
          r_ps  <= w_ps_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_sum   <= w_ps_next;
            r_cout  <= w_c;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // start is deliberately ignored here; the earliest re-accept is from IDLE.
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboarded bench for serial_adder (N=8): stimulus pushes expected {cout,sum},
// a negedge monitor pops and compares on every done pulse.
module tb_serial_adder;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;

  int errors;
  int checks;
  logic [N:0] exp_q[$];
  logic [N:0] last_res;
  logic       prev_done;

  serial_adder #(.N(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_done <= 1'b0;
    end else begin
      if (done) begin
        if (prev_done) chk("done_width", 32'd2, 32'd1);
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          logic [N:0] e;
          e = exp_q.pop_front();
          chk("result", {23'd0, cout, sum}, {23'd0, e});
        end
      end
      prev_done <= done;
    end
  end

  // Waits for done from the negedge after the accept edge; expects it after N negedges.
  task automatic wait_done(input string tag);
    int  k;
    int  busy_cnt;
    bit  seen;
    k = 0; busy_cnt = 1; seen = 0;
    while (!seen && k < 30) begin
      @(negedge clk);
      k++;
      if (done) seen = 1;
      else if (busy) busy_cnt++;
    end
    chk({tag, "_latency"}, seen ? k : 999, N);
    chk({tag, "_busy_cycles"}, busy_cnt, N);
    chk({tag, "_busy_low_at_done"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic do_op(input string tag, input logic [N-1:0] ta, input logic [N-1:0] tb,
                       input logic tc, input logic [N:0] texp, input bit hold);
    @(negedge clk);
    a = ta; b = tb; cin = tc; start = 1'b1;
    exp_q.push_back(texp);
    @(negedge clk);
    if (hold) begin
      a = 8'hAA; b = 8'h55;
    end else begin
      start = 1'b0;
      a = ~ta; b = ~tb; cin = ~tc;
    end
    chk({tag, "_busy_after_accept"}, {31'd0, busy}, 32'd1);
    chk({tag, "_result_holds"}, {23'd0, cout, sum}, {23'd0, last_res});
    wait_done(tag);
    last_res = texp;
  endtask

  initial begin
    errors = 0; checks = 0; last_res = '0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #23;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_sum",  {23'd0, cout, sum}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with start low: nothing moves.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_outputs", {22'd0, busy, done, cout, sum}, 32'd0);
    end

    do_op("t1", 8'h5A, 8'h3C, 1'b0, 9'h096, 1'b0);
    do_op("t2", 8'hFF, 8'h00, 1'b1, 9'h100, 1'b0);
    do_op("t3a", 8'hFF, 8'hFF, 1'b1, 9'h1FF, 1'b0);
    do_op("t3b", 8'h00, 8'h00, 1'b0, 9'h000, 1'b0);

    // start held high through ADD and DONE: no re-sample, no accept from DONE.
    do_op("t4", 8'h01, 8'h01, 1'b0, 9'h002, 1'b1);
    @(negedge clk);
    chk("t4_no_accept_in_done", {31'd0, busy}, 32'd0);
    chk("t4_done_single", {31'd0, done}, 32'd0);
    exp_q.push_back(9'h0FF);
    @(negedge clk);
    start = 1'b0;
    chk("t4_accept_from_idle", {31'd0, busy}, 32'd1);
    wait_done("t4b");
    last_res = 9'h0FF;

    // Async reset three bit steps into an operation.
    @(negedge clk);
    a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_sum",  {23'd0, cout, sum}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int dcnt;
      dcnt = 0;
      repeat (15) begin
        @(negedge clk);
        if (done || busy) dcnt++;
      end
      chk("arst_no_done_after", dcnt, 0);
    end
    last_res = '0;
    do_op("t5", 8'h80, 8'h80, 1'b0, 9'h100, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
